addsub_arb: RTL and testbench
=============================

# addsub_arb

Round-robin scheduler that shares one single-operation floating-point add/subtract unit (`addsub`) between N requesters in the motor-controller FPGA. It captures a requester's operands, drives the unit's start/operand inputs, waits for its done pulse, and routes the 32-bit result back to the winning requester. It also guards against a missing done pulse (timeout) and against stale done pulses after reset (drain window).

## Interface
- N, 4: number of requesters (2..8)
- TIMEOUT, 32: max cycles in WAIT before abort
- DRAIN, 16: post-reset cycles during which no grant is issued
- c  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  N  per-requester request level
- req_add_sub  in  N  per-requester op select, passed unchanged to fu_add_sub
- req_a  in  32*N  operand A; requester i occupies bits [32i+31:32i]
- req_b  in  32*N  operand B, same packing
- ack  out  N  one-hot, 1-cycle pulse: operands captured
- rsp_valid  out  N  one-hot, 1-cycle pulse: rsp_q valid for that requester
- rsp_q  out  32  result, shared by all requesters
- fu_a, fu_b  out  32 each  operands to the shared unit
- fu_add_sub  out  1  op select to the shared unit
- fu_start  out  1  start pulse to the shared unit
- fu_q  in  32  result from the shared unit
- fu_done  in  1  done pulse from the shared unit
- busy  out  1  high in every state other than IDLE
- err  out  1  sticky timeout flag; cleared only by reset

## Operation
- States:
  - DRAIN: entered on reset; counts DRAIN cycles, then goes to IDLE.
  - IDLE: if any req bit is high, grant and go to ISSUE.
  - ISSUE: go to WAIT.
  - WAIT: on fu_done or timeout, go to RESP.
  - RESP: go to IDLE.
- Arbitration (IDLE, req nonzero):
  - Winner w is the first set req bit searching upward from ptr, wrapping mod N.
  - At the same edge: op_a/op_b/op_add_sub ← requester w's fields, id ← w, ptr ← (w+1) mod N, ack[w] ← 1.
- ISSUE: fu_start = 1 for exactly this cycle.
- Unit interface: fu_a, fu_b, fu_add_sub are driven from the op registers and held stable from ISSUE until leaving RESP.
- WAIT:
  - wcnt increments each cycle.
  - If fu_done = 1: rsp_q ← fu_q, rsp_valid[id] ← 1.
  - Else if wcnt = TIMEOUT−1: rsp_q ← 32'h7FC00000 (quiet NaN), rsp_valid[id] ← 1, err ← 1.
- fu_done in any state other than WAIT is ignored.
- req is sampled only in IDLE.
  - A requester that drops req after its ack gets exactly one op.
  - A requester that holds req high is re-arbitrated after RESP, behind any other pending requesters under round-robin.
- Simultaneous requests: strictly round-robin; no requester waits more than N−1 grants.
- Reset mid-operation (rst_n low in any state):
  - All registers clear immediately; fu_start drops.
  - DRAIN absorbs any done pulse still in flight from the unit.

## Timing
- All outputs are registered except fu_a/fu_b/fu_add_sub, which are wired directly from the op registers.
- Reset values: ack=0, rsp_valid=0, rsp_q=0, fu_start=0, op regs=0 (so fu_a=fu_b=0 and fu_add_sub=0), busy=1 (DRAIN), err=0, ptr=0, state=DRAIN.
- Request sampled in IDLE at cycle t:
  - ack and ISSUE (fu_start) in cycle t+1.
  - WAIT from t+2.
  - fu_done in cycle d gives rsp_valid/rsp_q in cycle d+1 (RESP).
  - IDLE at d+2; the next grant is sampled no earlier than d+2.
- rsp_q holds its value until the next RESP.
- With the current addsub (done 15 cycles after start), request-to-response is 17 cycles; back-to-back throughput is one op per 18 cycles.

## Structure
- Package addsub_arb_pkg holds:
  - state enum (DRAIN, IDLE, ISSUE, WAIT, RESP)
  - QNAN constant 32'h7FC00000
  - helper for the counter width, $clog2(max(TIMEOUT, DRAIN))
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: any, winner index.
- Counters, op registers and the FSM live in addsub_arb.

## Test plan
- Reset release with N=4, req=4'b0001 held from reset → no ack for 16 cycles, then ack[0] in the first cycle after DRAIN; rsp_valid[0] with rsp_q=32'h40400000 for a=1.0, b=2.0, add.
- req=4'b1111 held continuously from ptr=0 → grant order 0,1,2,3,0; exactly one ack per grant; fu_start pulses are 18 cycles apart.
- Subtract on requester 2 (a=5.0, b=1.5, add_sub selects subtract) → rsp_valid=4'b0100, rsp_q=32'h40600000; fu_a/fu_b stable from ISSUE through RESP.
- Model with fu_done never asserted → rsp_valid[id] in cycle ISSUE+1+TIMEOUT with rsp_q=32'h7FC00000; err=1 and stays 1 until rst_n is asserted.
- Spurious fu_done injected in IDLE and in ISSUE → ignored; the real done in WAIT returns the correct result.
- rst_n pulsed low during WAIT → outputs return to reset values immediately; a stale fu_done arriving during DRAIN produces no rsp_valid.

Source files
------------

// File: rtl/addsub_arb_pkg.sv
// addsub_arb shared types: FSM states, NaN response, width helpers.
// Imported by the arbiter, its picker and its interface users.
package addsub_arb_pkg;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One counter serves both the drain window and the wait timeout
  function automatic int cnt_w(input int t, input int d);
    return ptr_w((t > d) ? t : d);
  endfunction

endpackage

// File: rtl/addsub_arb_if.sv
// Requester and add/sub unit bundle for addsub_arb.
// slave is the arbiter side, master is the requesters plus unit.
interface addsub_arb_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [N-1:0]    req_add_sub;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    ack;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_q;
  logic [31:0]     fu_a;
  logic [31:0]     fu_b;
  logic            fu_add_sub;
  logic            fu_start;
  logic [31:0]     fu_q;
  logic            fu_done;

  modport slave (
    input  req, req_add_sub, req_a, req_b,
    input  fu_q, fu_done,
    output ack, rsp_valid, rsp_q,
    output fu_a, fu_b, fu_add_sub, fu_start
  );

  modport master (
    output req, req_add_sub, req_a, req_b,
    output fu_q, fu_done,
    input  ack, rsp_valid, rsp_q,
    input  fu_a, fu_b, fu_add_sub, fu_start
  );
endinterface

// File: rtl/addsub_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or
// above ptr, wrapping modulo N.
module rr_pick
  import addsub_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] win
);
  localparam int SW = PW + 1;

  logic [SW-1:0] s;

  // Scan downward so the candidate nearest ptr is written last
  always_comb begin
    any = 1'b0;
    win = '0;
    s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + SW'(i);
      if (s >= SW'(N)) s = s - SW'(N);
      if (req[s[PW-1:0]]) begin
        any = 1'b1;
        win = s[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/addsub_arb.sv
// Round-robin sharing of one add/sub unit among N requesters,
// with done timeout and a post-reset drain window.
module addsub_arb
  import addsub_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 32,
  parameter int DRAIN   = 16
) (
  input  logic         c,
  input  logic         rst_n,
  addsub_arb_if.slave  bus,
  output logic         busy,
  output logic         err
);
  localparam int PW = ptr_w(N);
  localparam int CW = cnt_w(TIMEOUT, DRAIN);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] id_q, id_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          op_q, op_d;
  logic [31:0]   res_q, res_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  rv_q, rv_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          any;
  logic [PW-1:0] win;

  rr_pick #(.N(N)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (any),
    .win (win)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    ack_d   = '0;
    rv_d    = '0;
    start_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (any) begin
          state_d    = S_ISSUE;
          a_d        = bus.req_a[{win, 5'd0} +: 32];
          b_d        = bus.req_b[{win, 5'd0} +: 32];
          op_d       = bus.req_add_sub[win];
          id_d       = win;
          ptr_d      = (win == PW'(N - 1)) ?
                       '0 : win + PW'(1);
          ack_d[win] = 1'b1;
          start_d    = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.fu_done) begin
          state_d     = S_RESP;
          res_d       = bus.fu_q;
          rv_d[id_q]  = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          res_d       = QNAN;
          rv_d[id_q]  = 1'b1;
          err_d       = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DRAIN;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rsp_valid  = rv_q;
  assign bus.rsp_q      = res_q;
  assign bus.fu_start   = start_q;
  assign bus.fu_a       = a_q;
  assign bus.fu_b       = b_q;
  assign bus.fu_add_sub = op_q;
  assign busy           = busy_q;
  assign err            = err_q;
endmodule

// File: tb/tb_addsub_arb.sv
// Bench for addsub_arb: directed steps plus random traffic, checked
// against a round-robin/float model; the unit is a 15-cycle model.
module tb_addsub_arb;
  localparam int N = 4;
  localparam int TIMEOUT = 32;
  localparam int DRAIN = 16;
  localparam logic [31:0] NAN_Q = 32'h7FC0_0000;

  logic c = 1'b0;
  logic rst_n = 1'b1;
  logic busy, err;
  logic inj = 1'b0;
  bit   silent = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   mptr = 0;
  real  ra[N], rb[N];
  bit   rop[N];

  addsub_arb_if #(.N(N)) bus ();

  addsub_arb #(.N(N), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)) dut (
    .c     (c),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  function automatic logic [31:0] f32(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (r == 0.0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic real r64(input logic [31:0] f);
    if (f[30:0] == 31'h0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896,
                        f[22:0], 29'd0});
  endfunction

  function automatic real rnd();
    return real'($urandom_range(0, 2000)) / 16.0 - 40.0;
  endfunction

  // Unit model: done 15 cycles after start; add_sub=1 subtracts
  logic        m_done = 1'b0;
  logic [31:0] m_q = 32'h0;
  int          rem = 0;
  always @(posedge c) begin
    m_done <= 1'b0;
    if (bus.fu_start === 1'b1 && !silent) begin
      rem <= 14;
      m_q <= bus.fu_add_sub ?
             f32(r64(bus.fu_a) - r64(bus.fu_b)) :
             f32(r64(bus.fu_a) + r64(bus.fu_b));
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1) m_done <= 1'b1;
    end
  end
  assign bus.fu_done = m_done | inj;
  assign bus.fu_q    = m_q;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input real a, input real b,
                        input bit sub);
    ra[i] = a;
    rb[i] = b;
    rop[i] = sub;
    bus.req_a[32*i +: 32] = f32(a);
    bus.req_b[32*i +: 32] = f32(b);
    bus.req_add_sub[i] = sub;
  endtask

  // One grant/response round against the round-robin model
  task automatic serve(input bit drop, input bit spur,
                       output int ack_cyc);
    int w, k, extra;
    bit stable;
    logic [31:0] exp;
    w = -1;
    ack_cyc = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && bus.req[(mptr + i) % N]) w = (mptr + i) % N;
    if (w < 0) w = 0;
    k = 0;
    do begin
      @(negedge c);
      inj = 1'b0;
      k++;
    end while (bus.ack === '0 && k < 64);
    chk("ack", bus.ack, 64'(1) << w);
    if (bus.ack === '0) return;
    ack_cyc = cyc;
    chk("fu_start", bus.fu_start, 1);
    chk("fu_a", bus.fu_a, f32(ra[w]));
    chk("fu_b", bus.fu_b, f32(rb[w]));
    chk("fu_op", bus.fu_add_sub, rop[w]);
    mptr = (w + 1) % N;
    if (drop) bus.req[w] = 1'b0;
    if (spur) inj = 1'b1;
    stable = 1'b1;
    extra = 0;
    k = 0;
    do begin
      @(negedge c);
      inj = 1'b0;
      k++;
      if (bus.fu_a !== f32(ra[w]) || bus.fu_b !== f32(rb[w]) ||
          bus.fu_add_sub !== rop[w]) stable = 1'b0;
      if (bus.ack !== '0 || bus.fu_start !== 1'b0) extra++;
    end while (bus.rsp_valid === '0 && k < 80);
    exp = rop[w] ? f32(ra[w] - rb[w]) : f32(ra[w] + rb[w]);
    chk("rsp_valid", bus.rsp_valid, 64'(1) << w);
    chk("rsp_q", bus.rsp_q, silent ? NAN_Q : exp);
    chk("latency", k, silent ? 1 + TIMEOUT : 16);
    chk("fu_stable", stable, 1);
    chk("one_ack", extra, 0);
  endtask

  initial begin
    int t, bad;
    int st[5];
    bus.req = '0;
    bus.req_add_sub = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    set_op(0, 1.0, 2.0, 1'b0);
    bus.req = 4'b0001;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge c);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rv", bus.rsp_valid, 0);
    chk("rst_q", bus.rsp_q, 0);
    chk("rst_start", bus.fu_start, 0);
    chk("rst_fu_a", bus.fu_a, 0);
    chk("rst_fu_b", bus.fu_b, 0);
    chk("rst_fu_op", bus.fu_add_sub, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);

    // Drain window then the first add
    rst_n = 1'b1;
    t = cyc;
    serve(1'b1, 1'b0, st[0]);
    chk("drain_ack_cyc", st[0] - t, DRAIN + 1);
    chk("add_q", bus.rsp_q, 32'h4040_0000);

    // Bring ptr back to 0 via requester 3
    set_op(3, rnd(), rnd(), 1'b0);
    bus.req = 4'b1000;
    serve(1'b1, 1'b0, t);

    // All four requesting: order 0,1,2,3,0 at 18-cycle spacing
    for (int i = 0; i < N; i++) set_op(i, rnd(), rnd(), 1'($urandom_range(0, 1)));
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      serve(g == 4, 1'b0, st[g]);
      if (g > 0) chk("spacing", st[g] - st[g-1], 18);
    end
    bus.req = '0;

    // Subtract on requester 2; result held until next response
    set_op(2, 5.0, 1.5, 1'b1);
    bus.req = 4'b0100;
    serve(1'b1, 1'b0, t);
    chk("sub_q", bus.rsp_q, 32'h4060_0000);
    repeat (3) @(negedge c);
    chk("rsp_hold", bus.rsp_q, 32'h4060_0000);
    chk("err_pre", err, 0);

    // Unit never answers: timeout path
    silent = 1'b1;
    set_op(1, rnd(), rnd(), 1'b0);
    bus.req = 4'b0010;
    serve(1'b1, 1'b0, t);
    silent = 1'b0;
    chk("err_set", err, 1);

    // Spurious done in IDLE, then in ISSUE
    @(negedge c);
    inj = 1'b1;
    @(negedge c);
    inj = 1'b0;
    chk("spur_idle_rv", bus.rsp_valid, 0);
    @(negedge c);
    chk("spur_idle_busy", busy, 0);
    set_op(0, rnd(), rnd(), 1'b1);
    bus.req = 4'b0001;
    serve(1'b1, 1'b1, t);
    chk("err_sticky", err, 1);

    // Reset in WAIT, stale done lands inside the drain window
    set_op(3, rnd(), rnd(), 1'b0);
    bus.req = 4'b1000;
    t = 0;
    do begin
      @(negedge c);
      t++;
    end while (bus.ack === '0 && t < 64);
    chk("w_ack", bus.ack, 4'b1000);
    bus.req = '0;
    repeat (5) @(negedge c);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_rv", bus.rsp_valid, 0);
    chk("mid_q", bus.rsp_q, 0);
    chk("mid_start", bus.fu_start, 0);
    chk("mid_fu_a", bus.fu_a, 0);
    chk("err_clr", err, 0);
    repeat (2) @(negedge c);
    rst_n = 1'b1;
    mptr = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge c);
      if (bus.rsp_valid !== '0 || bus.ack !== '0) bad++;
    end
    chk("stale_drop", bad, 0);
    set_op(1, rnd(), rnd(), 1'b1);
    bus.req = 4'b0010;
    serve(1'b1, 1'b0, t);

    // Random traffic
    for (int it = 0; it < 12; it++) begin
      if (bus.req == '0) bus.req = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        set_op(i, rnd(), rnd(), 1'($urandom_range(0, 1)));
      serve($urandom_range(0, 1) == 1, 1'b0, t);
    end
    bus.req = '0;
    repeat (3) @(negedge c);
    chk("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
